// File: rtl/stream_rr_arbiter.sv
// Round-robin packet arbiter: N valid/ready streams onto one registered output.
// The grant is held per packet (or per beat when LOCK_ON_LAST=0).
module stream_rr_arbiter #(
  parameter int NUM_INPUTS   = 4,
  parameter int DATA_WIDTH   = 32,
  parameter bit LOCK_ON_LAST = 1'b1,
  localparam int ID_WIDTH    = (NUM_INPUTS == 1) ? 1 : $clog2(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  input  logic [NUM_INPUTS-1:0]            in_last,
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_last,
  output logic [ID_WIDTH-1:0]              out_id,
  output logic                             out_valid,
  input  logic                             out_ready
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d;
  logic [ID_WIDTH-1:0] prev_q, prev_d;

  logic                  load_en;
  logic                  accept;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [ID_WIDTH-1:0]   pick, pick_hi, pick_lo;
  logic                  found_hi;

  assign load_en = !out_valid || out_ready;
  assign accept  = (state_q == LOCKED) && sel_valid && load_en;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (ID_WIDTH'(i) == grant_q) begin
        sel_valid = in_valid[i];
        sel_last  = in_last[i];
        sel_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      in_ready[i] = resetn && (state_q == LOCKED) &&
                    (ID_WIDTH'(i) == grant_q) && load_en;
    end
  end

  // Lowest requester above prev wins; otherwise wrap to lowest overall.
  always_comb begin
    pick_hi  = '0;
    pick_lo  = '0;
    found_hi = 1'b0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        if (i > int'(prev_q)) begin
          pick_hi  = ID_WIDTH'(i);
          found_hi = 1'b1;
        end else begin
          pick_lo = ID_WIDTH'(i);
        end
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prev_d  = prev_q;
    unique case (state_q)
      IDLE: begin
        if (|in_valid) begin
          grant_d = pick;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (accept && (sel_last || !LOCK_ON_LAST)) begin
          prev_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      prev_q  <= ID_WIDTH'(NUM_INPUTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prev_q  <= prev_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_id    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
      out_id    <= grant_q;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench for stream_rr_arbiter: packet-locked and per-beat
// instances, producers modelled as per-input beat queues.
module tb_stream_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_last;
  logic [N-1:0]  in_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [IW-1:0] out_id;
  logic          out_valid;
  logic          out_ready;

  logic [N*DW-1:0] in_data2;
  logic [N-1:0]  in_valid2;
  logic [N-1:0]  in_last2;
  logic [N-1:0]  in_ready2;
  logic [DW-1:0] out_data2;
  logic          out_last2;
  logic [IW-1:0] out_id2;
  logic          out_valid2;
  logic          out_ready2;

  stream_rr_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .LOCK_ON_LAST(1'b1)) u_dut (
    .clk(clk), .resetn(resetn),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready),
    .out_data(out_data), .out_last(out_last), .out_id(out_id),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  stream_rr_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .LOCK_ON_LAST(1'b0)) u_dut_beat (
    .clk(clk), .resetn(resetn),
    .in_data(in_data2), .in_valid(in_valid2), .in_last(in_last2),
    .in_ready(in_ready2),
    .out_data(out_data2), .out_last(out_last2), .out_id(out_id2),
    .out_valid(out_valid2), .out_ready(out_ready2)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int out_cnt = 0;

  logic [32:0] src_q[N][$];
  logic [34:0] sb[$];
  int          stamps[$];
  logic [IW-1:0] ids2[$];
  logic [N-1:0]  hold = '0;
  logic [N-1:0]  fire;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] beat_data(int src, int j, int tag);
    return {tag[7:0], src[7:0], j[15:0]};
  endfunction

  task automatic pkt(input int src, input int n, input int tag);
    for (int j = 0; j < n; j++)
      src_q[src].push_back({(j == n - 1), beat_data(src, j, tag)});
  endtask

  task automatic expect_pkt(input int src, input int n, input int tag);
    logic [IW-1:0] id;
    id = IW'(src);
    for (int j = 0; j < n; j++)
      sb.push_back({id, (j == n - 1), beat_data(src, j, tag)});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int c;
    c = 0;
    while (sb.size() != 0 && c < budget) begin
      step(1);
      c++;
    end
    chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    logic [32:0] b;
    in_valid = '0;
    in_data  = '0;
    in_last  = '0;
    forever begin
      @(negedge clk);
      fire = in_valid & in_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (fire[i]) void'(src_q[i].pop_front());
      #1;
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() != 0 && !hold[i]) begin
          b = src_q[i][0];
          in_valid[i] = 1'b1;
          in_last[i]  = b[32];
          in_data[i*DW +: DW] = b[31:0];
        end else begin
          in_valid[i] = 1'b0;
          in_last[i]  = 1'b0;
          in_data[i*DW +: DW] = '0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [34:0] e;
    if (resetn && out_valid && out_ready) begin
      out_cnt++;
      stamps.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_beat", {out_id, out_last, out_data}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("beat", {out_id, out_last, out_data}, e);
      end
    end
    if (resetn && out_valid2 && ids2.size() < 8) ids2.push_back(out_id2);
  end

  initial begin
    logic [DW-1:0] d_hold;
    logic [IW-1:0] id_hold;
    logic          l_hold;
    int            base, c;

    out_ready  = 1'b1;
    in_valid2  = 4'b0101;
    in_last2   = '0;
    in_data2   = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    out_ready2 = 1'b1;

    // reset with all inputs requesting, then round robin over 1-beat packets
    for (int i = 0; i < N; i++) pkt(i, 1, 1);
    pkt(0, 1, 2);
    step(4);
    chk("rst_in_valid", 64'(in_valid), 64'hF);
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_id", 64'(out_id), 64'h0);
    chk("rst_out_data", 64'(out_data), 64'h0);
    for (int i = 0; i < N; i++) expect_pkt(i, 1, 1);
    expect_pkt(0, 1, 2);
    stamps.delete();
    resetn = 1'b1;
    wait_drain(100);
    chk("rr_count", 64'(stamps.size()), 64'd5);
    for (int i = 0; i + 1 < stamps.size(); i++)
      chk("rr_gap", 64'(stamps[i+1] - stamps[i]), 64'd2);
    step(3);

    // packet lock: input 1 four beats while input 2 waits
    pkt(1, 4, 3);
    pkt(2, 1, 3);
    expect_pkt(1, 4, 3);
    expect_pkt(2, 1, 3);
    wait_drain(100);
    step(3);

    // backpressure mid-packet on input 3
    pkt(3, 6, 4);
    expect_pkt(3, 6, 4);
    base = out_cnt;
    c = 0;
    while (out_cnt < base + 2 && c < 100) begin
      step(1);
      c++;
    end
    chk("bp_start_timeout", 64'(out_cnt >= base + 2), 64'd1);
    out_ready = 1'b0;
    @(negedge clk);
    d_hold  = out_data;
    id_hold = out_id;
    l_hold  = out_last;
    chk("bp_valid", 64'(out_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_data", 64'(out_data), 64'(d_hold));
      chk("bp_id_last", {id_hold, l_hold}, {out_id, out_last});
      chk("bp_in_ready", 64'(in_ready), 64'h0);
    end
    step(1);
    out_ready = 1'b1;
    wait_drain(100);
    step(3);

    // gap inside a packet while another input requests
    pkt(0, 4, 5);
    pkt(1, 1, 5);
    expect_pkt(0, 4, 5);
    expect_pkt(1, 1, 5);
    base = out_cnt;
    c = 0;
    while (out_cnt < base + 2 && c < 100) begin
      step(1);
      c++;
    end
    hold[0] = 1'b1;
    step(3);
    chk("gap_in_ready1", 64'(in_ready[1]), 64'd0);
    hold[0] = 1'b0;
    wait_drain(100);
    step(3);

    // per-beat instance: alternation, then reset mid-stream
    chk("beat_ids_n", 64'(ids2.size() >= 4), 64'd1);
    if (ids2.size() >= 4) begin
      chk("beat_id0", 64'(ids2[0]), 64'd0);
      chk("beat_id1", 64'(ids2[1]), 64'd2);
      chk("beat_id2", 64'(ids2[2]), 64'd0);
      chk("beat_id3", 64'(ids2[3]), 64'd2);
    end
    c = 0;
    while (!out_valid2 && c < 20) begin
      step(1);
      c++;
    end
    chk("beat_valid_seen", 64'(out_valid2), 64'd1);
    resetn = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid2), 64'd0);
    chk("midrst_in_ready", 64'(in_ready2), 64'h0);
    chk("midrst_out_id", 64'(out_id2), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
